// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: reset level,
// FSM states and mem_len codes.
package mem_ctrl_pkg;

   localparam logic RST_ENABLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IF_RD  = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [1:0] LEN_B = 2'b00;
   localparam logic [1:0] LEN_H = 2'b01;
   localparam logic [1:0] LEN_W = 2'b10;

   // Byte count for a mem_len code; the reserved code behaves as a word.
   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      case (len)
         LEN_B:   len_bytes = 3'd1;
         LEN_H:   len_bytes = 3'd2;
         LEN_W:   len_bytes = 3'd4;
         default: len_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// onto an 8-bit synchronous RAM, assembling/splitting 32-bit words inline.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_len,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   output logic        stall_req_if,
   output logic        stall_req_mem,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr
);

   state_t      state, state_n;
   logic [31:0] base, base_n;
   logic [2:0]  n, n_n;
   logic [31:0] wdata, wdata_n;
   logic [2:0]  cnt, cnt_n, nxt;
   logic [31:0] asm_buf, asm_n, lane_buf;
   logic [31:0] ram_a_n;
   logic [7:0]  ram_dout_n;
   logic        ram_wr_n, if_done_n, mem_done_n;
   logic [31:0] if_inst_n, mem_rdata_n;

   assign stall_req_if  = if_req  & ~if_done;
   assign stall_req_mem = mem_req & ~mem_done;

   always_comb begin
      state_n     = state;
      base_n      = base;
      n_n         = n;
      wdata_n     = wdata;
      cnt_n       = cnt;
      asm_n       = asm_buf;
      ram_a_n     = '0;
      ram_dout_n  = '0;
      ram_wr_n    = 1'b0;
      if_done_n   = 1'b0;
      mem_done_n  = 1'b0;
      if_inst_n   = if_inst;
      mem_rdata_n = mem_rdata;
      nxt         = cnt + 3'd1;

      // RAM read data lags the address by one cycle, so at cnt=k the byte
      // arriving on ram_din belongs to lane k-1.
      lane_buf = asm_buf;
      case (cnt)
         3'd1:    lane_buf[7:0]   = ram_din;
         3'd2:    lane_buf[15:8]  = ram_din;
         3'd3:    lane_buf[23:16] = ram_din;
         3'd4:    lane_buf[31:24] = ram_din;
         default: ;
      endcase

      case (state)
         IDLE: begin
            cnt_n = '0;
            asm_n = '0;
            if (mem_req) begin
               base_n  = mem_addr;
               n_n     = len_bytes(mem_len);
               wdata_n = mem_wdata;
               ram_a_n = mem_addr;
               if (mem_we) begin
                  ram_dout_n = mem_wdata[7:0];
                  ram_wr_n   = 1'b1;
                  state_n    = MEM_WR;
               end else begin
                  state_n = MEM_RD;
               end
            end else if (if_req) begin
               base_n  = if_addr;
               n_n     = 3'd4;
               ram_a_n = if_addr;
               state_n = IF_RD;
            end
         end
         IF_RD, MEM_RD: begin
            if (state == IF_RD && !if_req) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = nxt;
               asm_n = lane_buf;
               if (nxt < n)
                  ram_a_n = base + {29'd0, nxt};
               if (cnt == n) begin
                  state_n = DONE;
                  cnt_n   = '0;
                  if (state == IF_RD) begin
                     if_done_n = 1'b1;
                     if_inst_n = lane_buf;
                  end else begin
                     mem_done_n  = 1'b1;
                     mem_rdata_n = lane_buf;
                  end
               end
            end
         end
         MEM_WR: begin
            cnt_n = nxt;
            if (nxt < n) begin
               ram_a_n    = base + {29'd0, nxt};
               ram_dout_n = wdata[{nxt[1:0], 3'b000} +: 8];
               ram_wr_n   = 1'b1;
            end else begin
               mem_done_n = 1'b1;
               state_n    = DONE;
               cnt_n      = '0;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state     <= IDLE;
         base      <= '0;
         n         <= '0;
         wdata     <= '0;
         cnt       <= '0;
         asm_buf   <= '0;
         ram_a     <= '0;
         ram_dout  <= '0;
         ram_wr    <= 1'b0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
         if_inst   <= '0;
         mem_rdata <= '0;
      end else begin
         state     <= state_n;
         base      <= base_n;
         n         <= n_n;
         wdata     <= wdata_n;
         cnt       <= cnt_n;
         asm_buf   <= asm_n;
         ram_a     <= ram_a_n;
         ram_dout  <= ram_dout_n;
         ram_wr    <= ram_wr_n;
         if_done   <= if_done_n;
         mem_done  <= mem_done_n;
         if_inst   <= if_inst_n;
         mem_rdata <= mem_rdata_n;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transfers push expected RAM traffic
// and done events; a negedge monitor pops and compares what the DUT presents.
module tb_mem_ctrl;

   logic        clk, rst;
   logic        if_req, if_done;
   logic [31:0] if_addr, if_inst;
   logic        mem_req, mem_we, mem_done;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall_req_if, stall_req_mem;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   typedef struct {
      bit          is_mem;
      bit          chk_data;
      logic [31:0] data;
   } done_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   done_t       exp_done[$];
   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] rom(input logic [31:0] a);
      case (a)
         32'h1000: rom = 8'h13;
         32'h1001: rom = 8'h05;
         32'h0020: rom = 8'hF0;
         32'h0021: rom = 8'hAA;
         32'h0101: rom = 8'h34;
         32'h0102: rom = 8'h12;
         32'h0200: rom = 8'h01;
         32'h0201: rom = 8'h02;
         32'h0202: rom = 8'h03;
         32'h0203: rom = 8'h04;
         32'h0300: rom = 8'h77;
         32'h0301: rom = 8'h66;
         default:  rom = 8'h00;
      endcase
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM read: data for ram_a shows up one cycle later.
   always @(posedge clk) ram_din <= rom(ram_a);

   always @(negedge clk) begin
      if (!rst) begin
         if (if_done || mem_done) begin
            if (exp_done.size() == 0) begin
               check("unexpected_done", {30'd0, if_done, mem_done}, 32'd0);
            end else begin
               done_t e;
               e = exp_done.pop_front();
               check("done_kind", {30'd0, if_done, mem_done}, e.is_mem ? 32'd1 : 32'd2);
               if (e.chk_data) check("done_data", mem_done ? mem_rdata : if_inst, e.data);
            end
         end
         if (ram_wr) begin
            if (exp_wr.size() == 0) begin
               check("unexpected_wr", ram_a, 32'hFFFF_FFFF);
            end else begin
               wr_t w;
               w = exp_wr.pop_front();
               check("wr_addr", ram_a, w.addr);
               check("wr_data", {24'd0, ram_dout}, {24'd0, w.data});
            end
         end else if (ram_a != 32'd0) begin
            if (exp_rd.size() == 0) check("unexpected_rd", ram_a, 32'd0);
            else check("rd_addr", ram_a, exp_rd.pop_front());
         end
      end
   end

   task automatic wait_done(input bit is_mem, output int cyc);
      int c;
      c   = 0;
      cyc = -1;
      while (cyc < 0 && c < 30) begin
         @(negedge clk);
         c++;
         if (is_mem ? mem_done : if_done) cyc = c;
      end
   endtask

   task automatic push_rd(input logic [31:0] a, input int nb);
      for (int i = 0; i < nb; i++) exp_rd.push_back(a + i);
   endtask

   initial begin
      int    cyc, c, gap;
      bit    stall_ok, no_done;
      done_t d;
      wr_t   w;

      rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
      mem_len = 0; mem_addr = 0; mem_wdata = 0;
      #12;
      check("rst_ram_a", ram_a, 32'd0);
      check("rst_ram_wr_dout", {23'd0, ram_wr, ram_dout}, 32'd0);
      check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
      check("rst_if_inst", if_inst, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      @(negedge clk) rst = 1'b0;

      // IF fetch of 0x0000_0513
      @(negedge clk);
      if_addr = 32'h1000; if_req = 1'b1;
      push_rd(32'h1000, 4);
      d = '{is_mem: 1'b0, chk_data: 1'b1, data: 32'h0000_0513}; exp_done.push_back(d);
      wait_done(1'b0, cyc);
      check("if_latency", cyc, 6);
      if_req = 1'b0;

      // Word store straddling 0x1000
      @(negedge clk);
      mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h0FFE; mem_wdata = 32'hDEAD_BEEF; mem_req = 1'b1;
      w = '{addr: 32'h0FFE, data: 8'hEF}; exp_wr.push_back(w);
      w = '{addr: 32'h0FFF, data: 8'hBE}; exp_wr.push_back(w);
      w = '{addr: 32'h1000, data: 8'hAD}; exp_wr.push_back(w);
      w = '{addr: 32'h1001, data: 8'hDE}; exp_wr.push_back(w);
      d = '{is_mem: 1'b1, chk_data: 1'b0, data: 32'd0}; exp_done.push_back(d);
      wait_done(1'b1, cyc);
      check("st_latency", cyc, 5);
      mem_req = 1'b0;

      // Byte load, upper lanes must be zero
      @(negedge clk);
      mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20; mem_req = 1'b1;
      push_rd(32'h20, 1);
      d = '{is_mem: 1'b1, chk_data: 1'b1, data: 32'h0000_00F0}; exp_done.push_back(d);
      wait_done(1'b1, cyc);
      check("ldb_latency", cyc, 3);
      mem_req = 1'b0;

      // Simultaneous IF and unaligned half load: MEM wins
      @(negedge clk);
      mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h101; mem_req = 1'b1;
      if_addr = 32'h200; if_req = 1'b1;
      push_rd(32'h101, 2);
      push_rd(32'h200, 4);
      d = '{is_mem: 1'b1, chk_data: 1'b1, data: 32'h0000_1234}; exp_done.push_back(d);
      d = '{is_mem: 1'b0, chk_data: 1'b1, data: 32'h0403_0201}; exp_done.push_back(d);
      stall_ok = 1'b1;
      cyc = -1; c = 0;
      while (cyc < 0 && c < 30) begin
         @(negedge clk); c++;
         if (!stall_req_if) stall_ok = 1'b0;
         if (mem_done) cyc = c;
      end
      check("ldh_latency", cyc, 4);
      mem_req = 1'b0;
      gap = -1; c = 0;
      while (gap < 0 && c < 10) begin
         @(negedge clk); c++;
         if (!stall_req_if) stall_ok = 1'b0;
         if (ram_a == 32'h200) gap = c;
      end
      check("if_after_mem_gap", gap, 2);
      cyc = -1; c = 0;
      while (cyc < 0 && c < 30) begin
         @(negedge clk); c++;
         if (if_done) cyc = c;
         else if (!stall_req_if) stall_ok = 1'b0;
      end
      check("stall_if_at_done", {31'd0, stall_req_if}, 32'd0);
      check("stall_if_held", {31'd0, stall_ok}, 32'd1);
      if_req = 1'b0;

      // IF withdrawn before E2
      @(negedge clk);
      if_addr = 32'h300; if_req = 1'b1;
      push_rd(32'h300, 2);
      @(negedge clk);
      @(negedge clk);
      if_req = 1'b0;
      @(negedge clk);
      check("abort_idle_ram_a", ram_a, 32'd0);
      no_done = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (if_done) no_done = 1'b0;
      end
      check("abort_no_done", {31'd0, no_done}, 32'd1);
      check("abort_if_inst", if_inst, 32'h0403_0201);

      // Reset after two bytes of a store
      @(negedge clk);
      mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h400; mem_wdata = 32'h1122_3344; mem_req = 1'b1;
      w = '{addr: 32'h400, data: 8'h44}; exp_wr.push_back(w);
      w = '{addr: 32'h401, data: 8'h33}; exp_wr.push_back(w);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1; mem_req = 1'b0;
      #1;
      check("midrst_ram_wr", {31'd0, ram_wr}, 32'd0);
      check("midrst_ram_a", ram_a, 32'd0);
      check("midrst_mem_rdata", mem_rdata, 32'd0);
      check("midrst_if_inst", if_inst, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20; mem_req = 1'b1;
      push_rd(32'h20, 1);
      d = '{is_mem: 1'b1, chk_data: 1'b1, data: 32'h0000_00F0}; exp_done.push_back(d);
      wait_done(1'b1, cyc);
      check("post_rst_latency", cyc, 3);
      mem_req = 1'b0;
      repeat (4) @(negedge clk);

      check("left_done", exp_done.size(), 0);
      check("left_wr", exp_wr.size(), 0);
      check("left_rd", exp_rd.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
